// File: rtl/motor_ctrl_pkg.sv
// Shared definitions for the UART command responder and motor register bank.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//   state_e         : responder FSM encoding (3 bits, 8 states)
//   *_DEF constants : default command/response bytes and frame timeout
//   REG_*           : motor-control register bank address map
package motor_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_GET_ADDR   = 3'd1,
        ST_GET_DATA   = 3'd2,
        ST_REG_WRITE  = 3'd3,
        ST_REG_READ   = 3'd4,
        ST_READ_WAIT  = 3'd5,
        ST_SEND       = 3'd6,
        ST_WAIT_DONE  = 3'd7
    } state_e;

    localparam int          TIMEOUT_CYCLES_DEF = 50_000;  // 1 ms at 50 MHz
    localparam logic [7:0]  CMD_WRITE_DEF      = 8'h57;   // 'W'
    localparam logic [7:0]  CMD_READ_DEF       = 8'h52;   // 'R'
    localparam logic [7:0]  ACK_BYTE_DEF       = 8'h06;
    localparam logic [7:0]  NAK_BYTE_DEF       = 8'h15;

    // Motor-control register bank
    localparam logic [7:0]  REG_PWM_DUTY       = 8'h00;
    localparam logic [7:0]  REG_DIRECTION      = 8'h01;
    localparam logic [7:0]  REG_ENABLE         = 8'h02;

endpackage

// File: rtl/uart_cmd_responder.sv
// Parses W/R command frames from UART rx bytes, drives single-byte register
// accesses and returns one response byte per frame via the tx handshake.
// Latency: NAK 1 cycle after the byte; write response 2 cycles, read 3 cycles after the last byte.
// Backpressure: none on rx; bytes arriving while a frame is executing or responding are dropped.
// Ports:
//   clock, srst                       : clock and synchronous active-high reset
//   rx_value, rx_value_ready          : received byte and its one-cycle strobe
//   tx_value, tx_value_write, tx_value_done : response byte, start pulse, completion pulse
//   reg_addr, reg_wdata, reg_write, reg_read, reg_rdata : register-bus master
//   busy, timeout_pulse               : status
module uart_cmd_responder
    import motor_ctrl_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter logic [7:0]  CMD_WRITE      = CMD_WRITE_DEF,
    parameter logic [7:0]  CMD_READ       = CMD_READ_DEF,
    parameter logic [7:0]  ACK_BYTE       = ACK_BYTE_DEF,
    parameter logic [7:0]  NAK_BYTE       = NAK_BYTE_DEF
) (
    input  logic        clock,
    input  logic        srst,
    input  logic [7:0]  rx_value,
    input  logic        rx_value_ready,
    output logic [7:0]  tx_value,
    output logic        tx_value_write,
    input  logic        tx_value_done,
    output logic [7:0]  reg_addr,
    output logic [7:0]  reg_wdata,
    output logic        reg_write,
    output logic        reg_read,
    input  logic [7:0]  reg_rdata,
    output logic        busy,
    output logic        timeout_pulse
);

    localparam int             CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_e          state_q,     state_d;
    logic            is_write_q,  is_write_d;
    logic [7:0]      reg_addr_q,  reg_addr_d;
    logic [7:0]      reg_wdata_q, reg_wdata_d;
    logic [7:0]      tx_byte_q,   tx_byte_d;
    logic [CW-1:0]   cnt_q,       cnt_d;

    always_ff @(posedge clock) begin
        if (srst) begin
            state_q     <= ST_IDLE;
            is_write_q  <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            tx_byte_q   <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            is_write_q  <= is_write_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            tx_byte_q   <= tx_byte_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        is_write_d     = is_write_q;
        reg_addr_d     = reg_addr_q;
        reg_wdata_d    = reg_wdata_q;
        tx_byte_d      = tx_byte_q;
        // Counter only runs while waiting for the rest of a frame; every
        // other path (including an accepted byte) leaves it cleared.
        cnt_d          = '0;
        reg_write      = 1'b0;
        reg_read       = 1'b0;
        tx_value_write = 1'b0;
        timeout_pulse  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rx_value_ready) begin
                    if (rx_value == CMD_WRITE) begin
                        is_write_d = 1'b1;
                        state_d    = ST_GET_ADDR;
                    end else if (rx_value == CMD_READ) begin
                        is_write_d = 1'b0;
                        state_d    = ST_GET_ADDR;
                    end else begin
                        tx_byte_d  = NAK_BYTE;
                        state_d    = ST_SEND;
                    end
                end
            end

            ST_GET_ADDR: begin
                // An arriving byte beats expiry in the same cycle.
                if (rx_value_ready) begin
                    reg_addr_d = rx_value;
                    state_d    = is_write_q ? ST_GET_DATA : ST_REG_READ;
                end else if (cnt_q == TMO_LAST) begin
                    timeout_pulse = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_GET_DATA: begin
                if (rx_value_ready) begin
                    reg_wdata_d = rx_value;
                    state_d     = ST_REG_WRITE;
                end else if (cnt_q == TMO_LAST) begin
                    timeout_pulse = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_REG_WRITE: begin
                reg_write = 1'b1;
                tx_byte_d = ACK_BYTE;
                state_d   = ST_SEND;
            end

            ST_REG_READ: begin
                reg_read = 1'b1;
                state_d  = ST_READ_WAIT;
            end

            ST_READ_WAIT: begin
                // Slave returns data exactly one cycle after the strobe.
                tx_byte_d = reg_rdata;
                state_d   = ST_SEND;
            end

            ST_SEND: begin
                tx_value_write = 1'b1;
                state_d        = ST_WAIT_DONE;
            end

            ST_WAIT_DONE: begin
                if (tx_value_done) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // tx_byte_q only changes on entry to SEND, so it is stable from the
    // write pulse until the done pulse.
    assign tx_value  = tx_byte_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
